ram_share_ctrl: RTL and testbench
=================================

# ram_share_ctrl

Two-port RAM controller and arbiter that shares the 256×32 dual-port scratch RAM among NREQ independent requesters and sequences a full-memory clear. Each cycle it selects up to two requests by rotating priority, maps them onto RAM port 1 and port 2, and returns read data with a per-requester valid pulse. It sits between the requester blocks and the RAM, and is the only driver of the RAM enables, addresses and write data.

## Interface
- NREQ, 4, number of requesters (2–8)
- AW, 8, RAM address width (RAM depth 2^AW)
- DW, 32, data width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester; held until granted
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- gnt  out  NREQ  one-cycle acceptance pulse per requester
- rsp_valid  out  NREQ  read-data-valid pulse per requester
- rsp_data  out  NREQ*DW  flattened read data, valid with rsp_valid[i]
- clr_start  in  1  pulse: zero the whole RAM
- busy  out  1  high while clearing
- clr_done  out  1  one-cycle pulse at end of clear
- ram_en1, ram_en2  out  1  RAM port write enables
- ram_addr1, ram_addr2  out  AW  RAM port addresses
- ram_din1, ram_din2  out  DW  RAM port write data
- ram_dout1, ram_dout2  in  DW  RAM combinational read data

## Operation
- States: ARB, CLEAR, DONE. Reset → ARB.
- ARB: scan req starting at pointer ptr, wrapping modulo NREQ. First hit → port 1, second hit → port 2. Max two grants per cycle.
- Conflict: if the second candidate has the same address as the first and either is a write, the second is not granted this cycle; the scan continues for a third non-conflicting candidate.
- ptr advances to (index of last granted requester + 1) mod NREQ; it is unchanged when nothing is granted.
- A write drives ram_en=1, ram_addr and ram_din on its port. A read drives ram_en=0 and ram_addr; ram_dout is captured into that requester's rsp_data slot.
- An unused port has en=0 and holds its previous address.
- After gnt the requester may change or drop req; a held req is a new request.
- ARB with clr_start=1 → CLEAR, and no grants issue that cycle (clear wins). Counter k=0.
- CLEAR: each cycle write 0 to address k on port 1 and k+1 on port 2; k += 2. After the write at k = 2^AW−2, go to DONE. No grants are issued; req is ignored but not lost.
- DONE: clr_done=1 for one cycle, then → ARB.
- clr_start is ignored in CLEAR and DONE.
- Reads granted before CLEAR still complete their rsp_valid.
- Async reset mid-operation: all state, ptr, k and outputs clear immediately; in-flight reads are dropped.

## Timing
- gnt is combinational from req, state and ptr in cycle T.
- ram_* are registered and present the transaction in T+1.
- Read data is sampled from ram_dout at the end of T+1. rsp_valid[i] and rsp_data are high/valid in T+2, so gnt→rsp latency is 2 cycles. rsp_data holds until the next read for that requester.
- Throughput: 2 transactions per cycle when no conflicts occur.
- Clear on AW=8: busy rises the cycle after clr_start and stays high for 128 cycles. clr_done follows one cycle after busy falls. First grant is possible in the cycle after clr_done.
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, busy=0, clr_done=0, ram_en1/2=0, ram_addr1/2=0, ram_din1/2=0, ptr=0.

## Test plan
- Write/read: req0 writes 0xDEADBEEF to 0x10, then req0 reads 0x10 → gnt0 each time; rsp_valid[0] 2 cycles after the read gnt, with rsp_data[0]=0xDEADBEEF.
- Dual issue: req1 reads 0x05 and req2 writes 0x22 in the same cycle at ptr=0 → both gnt the same cycle; req1 is on port 1, req2 on port 2; ptr becomes 3.
- Fairness: all four requesters hold reads to distinct addresses → grant pairs {0,1}, {2,3}, {0,1}…; no requester waits more than 2 cycles.
- Conflict: req0 and req1 both write address 0x40 → only gnt0 in cycle T, gnt1 in T+1; the final RAM value is req1's data.
- Clear: fill addresses 0x00, 0x81, 0xFF, then pulse clr_start with req3 high → busy for 128 cycles, clr_done pulse, no gnt3 until after clr_done; reads of all three addresses return 0.
- Reset mid-clear: drop rst_n at k=0x40 → busy=0 and ram_en1/2=0 immediately; state is ARB after release.

Source files
------------

// File: rtl/ram_share_if.sv
// Requester-side and RAM-side signal bundle for ram_share_ctrl.
// slave = the controller, master = the requesters plus the RAM.
interface ram_share_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req, req_we, gnt, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rsp_data;
  logic               ram_en1, ram_en2;
  logic [AW-1:0]      ram_addr1, ram_addr2;
  logic [DW-1:0]      ram_din1, ram_din2, ram_dout1, ram_dout2;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_dout1, ram_dout2,
    output gnt, rsp_valid, rsp_data,
    output ram_en1, ram_en2, ram_addr1, ram_addr2, ram_din1, ram_din2
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ram_dout1, ram_dout2,
    input  gnt, rsp_valid, rsp_data,
    input  ram_en1, ram_en2, ram_addr1, ram_addr2, ram_din1, ram_din2
  );
endinterface

// File: rtl/ram_share_ctrl.sv
// Dual-port scratch RAM sharer: rotating-priority two-grant arbiter,
// per-requester read-response capture, and a two-words-per-cycle clear.

module ram_share_rsp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hit1,
  input  logic          hit2,
  input  logic [DW-1:0] dout1,
  input  logic [DW-1:0] dout2,
  output logic          vld,
  output logic [DW-1:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else begin
      vld <= hit1 | hit2;
      if (hit1)      data <= dout1;
      else if (hit2) data <= dout2;
    end
  end
endmodule

module ram_share_ctrl #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_share_if.slave    bus,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] K_LAST = {{(AW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {ARB, CLEAR, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]   ptr, ptr_nxt, id1, id2;
  logic            hit1, hit2, arb_en;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   k;
  logic            en1, en2;
  logic [AW-1:0]   addr1, addr2;
  logic [DW-1:0]   din1, din2;
  logic            rd1_vld, rd2_vld;
  logic [PW-1:0]   rd1_id, rd2_id;
  logic [NREQ-1:0]         rsp_vld_w;
  logic [NREQ-1:0][DW-1:0] rsp_data_w;

  // Rotating scan from ptr; second pick must not alias the first when a write is involved.
  always_comb begin : arb
    int idx;
    idx    = 0;
    hit1   = 1'b0;
    hit2   = 1'b0;
    id1    = '0;
    id2    = '0;
    gnt    = '0;
    arb_en = rst_n && (state == ARB) && !clr_start;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(ptr) + j) % NREQ;
      if (arb_en && bus.req[idx]) begin
        if (!hit1) begin
          hit1 = 1'b1;
          id1  = PW'(idx);
        end else if (!hit2 &&
                     !((bus.req_addr[idx*AW +: AW] == bus.req_addr[int'(id1)*AW +: AW]) &&
                       (bus.req_we[idx] || bus.req_we[id1]))) begin
          hit2 = 1'b1;
          id2  = PW'(idx);
        end
      end
    end
    if (hit1) gnt[id1] = 1'b1;
    if (hit2) gnt[id2] = 1'b1;
    ptr_nxt = ptr;
    if (hit2)      ptr_nxt = PW'((int'(id2) + 1) % NREQ);
    else if (hit1) ptr_nxt = PW'((int'(id1) + 1) % NREQ);
  end

  always_comb begin : fsm
    state_nxt = state;
    case (state)
      ARB:     if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      ptr     <= '0;
      k       <= '0;
      en1     <= 1'b0;
      en2     <= 1'b0;
      addr1   <= '0;
      addr2   <= '0;
      din1    <= '0;
      din2    <= '0;
      rd1_vld <= 1'b0;
      rd2_vld <= 1'b0;
      rd1_id  <= '0;
      rd2_id  <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      en1     <= 1'b0;
      en2     <= 1'b0;
      rd1_vld <= 1'b0;
      rd2_vld <= 1'b0;
      if (state == CLEAR) begin
        en1   <= 1'b1;
        en2   <= 1'b1;
        addr1 <= k;
        addr2 <= k + AW'(1);
        din1  <= '0;
        din2  <= '0;
        k     <= k + AW'(2);
      end else begin
        k <= '0;
        // Idle ports keep their last address; read data is tagged with the requester id.
        if (hit1) begin
          en1     <= bus.req_we[id1];
          addr1   <= bus.req_addr[int'(id1)*AW +: AW];
          rd1_vld <= !bus.req_we[id1];
          rd1_id  <= id1;
          if (bus.req_we[id1]) din1 <= bus.req_wdata[int'(id1)*DW +: DW];
        end
        if (hit2) begin
          en2     <= bus.req_we[id2];
          addr2   <= bus.req_addr[int'(id2)*AW +: AW];
          rd2_vld <= !bus.req_we[id2];
          rd2_id  <= id2;
          if (bus.req_we[id2]) din2 <= bus.req_wdata[int'(id2)*DW +: DW];
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    ram_share_rsp #(.DW(DW)) u_rsp (
      .clk   (clk),
      .rst_n (rst_n),
      .hit1  (rd1_vld && (rd1_id == PW'(i))),
      .hit2  (rd2_vld && (rd2_id == PW'(i))),
      .dout1 (bus.ram_dout1),
      .dout2 (bus.ram_dout2),
      .vld   (rsp_vld_w[i]),
      .data  (rsp_data_w[i])
    );
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_vld_w;
  assign bus.rsp_data  = rsp_data_w;
  assign bus.ram_en1   = en1;
  assign bus.ram_en2   = en2;
  assign bus.ram_addr1 = addr1;
  assign bus.ram_addr2 = addr2;
  assign bus.ram_din1  = din1;
  assign bus.ram_din2  = din2;
  assign busy          = (state == CLEAR);
  assign clr_done      = (state == DONE);
endmodule

// File: tb/tb_ram_share_ctrl.sv
// Directed bench for ram_share_ctrl: vector table for arbitration/data path,
// hand sequences for clear and reset-during-clear. Holds its own RAM model.
module tb_ram_share_ctrl;
  localparam int NREQ = 4, AW = 8, DW = 32;

  logic clk = 1'b0, rst_n = 1'b1, clr_start = 1'b0, mem_clr = 1'b1;
  logic busy, clr_done;
  int   n_tests = 0, n_fail = 0;

  ram_share_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  ram_share_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else begin
      if (bus.ram_en1) mem[bus.ram_addr1] <= bus.ram_din1;
      if (bus.ram_en2) mem[bus.ram_addr2] <= bus.ram_din2;
    end
  end
  assign bus.ram_dout1 = mem[bus.ram_addr1];
  assign bus.ram_dout2 = mem[bus.ram_addr2];

  typedef struct {
    logic [3:0]   req, we;
    logic [31:0]  addr;
    logic [127:0] wd;
    logic [3:0]   gnt;
    logic         en1;
    logic [7:0]   a1;
    logic [31:0]  d1;
    logic         en2;
    logic [7:0]   a2;
    logic [31:0]  d2;
    logic [3:0]   rv;
    logic [127:0] rd;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic [3:0] we, logic [31:0] addr,
                              logic [127:0] wd, logic [3:0] gnt,
                              logic en1, logic [7:0] a1, logic [31:0] d1,
                              logic en2, logic [7:0] a2, logic [31:0] d2,
                              logic [3:0] rv, logic [127:0] rd);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wd = wd; v.gnt = gnt;
    v.en1 = en1; v.a1 = a1; v.d1 = d1; v.en2 = en2; v.a2 = a2; v.d2 = d2;
    v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Raise one request from posedge+1, wait (bounded) for its grant; returns at posedge+1 after gnt.
  task automatic issue(input int i, input logic we, input logic [7:0] a, input logic [31:0] d,
                       output bit ok);
    bus.req[i] = 1'b1;
    bus.req_we[i] = we;
    bus.req_addr[i*8 +: 8] = a;
    bus.req_wdata[i*32 +: 32] = d;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.gnt[i]) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.req[i] = 1'b0;
  endtask

  task automatic do_wr(input int i, input logic [7:0] a, input logic [31:0] d);
    bit ok;
    issue(i, 1'b1, a, d, ok);
    chk($sformatf("wr%0d gnt @%0h", i, a), ok, 1);
  endtask

  task automatic do_rd(input int i, input logic [7:0] a, input logic [31:0] exp);
    bit ok;
    issue(i, 1'b0, a, 32'h0, ok);
    chk($sformatf("rd%0d gnt @%0h", i, a), ok, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("rd%0d rsp_valid @%0h", i, a), bus.rsp_valid[i], 1);
    chk($sformatf("rd%0d rsp_data @%0h", i, a), bus.rsp_data[i*32 +: 32], exp);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] RD0 = '0;
  localparam logic [127:0] RD1 = {96'h0, 32'hDEADBEEF};
  localparam logic [127:0] RD2 = {96'h0, 32'h12345678};
  localparam logic [127:0] RD3 = {32'h0, 32'h5555AAAA, 32'h5555AAAA, 32'h0};
  localparam int NV = 16;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v [NV];
    bit   ok;
    int   bcnt, bad, nz;

    // ram columns are the outputs visible during that row (previous row's grants)
    v[0]  = mk(4'b0001, 4'b0001, 32'h00000010, {96'h0, 32'hDEADBEEF}, 4'b0001,
               1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, 4'b0000, RD0);
    v[1]  = mk(4'b0001, 4'b0000, 32'h00000010, 128'h0, 4'b0001,
               1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0, 4'b0000, RD0);
    v[2]  = mk(4'b1000, 4'b0000, 32'h30000000, 128'h0, 4'b1000,
               1'b0, 8'h10, 32'h0, 1'b0, 8'h00, 32'h0, 4'b0000, RD0);
    v[3]  = mk(4'b0110, 4'b0100, 32'h00220500, {32'h0, 32'h12345678, 64'h0}, 4'b0110,
               1'b0, 8'h30, 32'h0, 1'b0, 8'h00, 32'h0, 4'b0001, RD1);
    v[4]  = mk(4'b1001, 4'b0000, 32'h05000022, 128'h0, 4'b1001,
               1'b0, 8'h05, 32'h0, 1'b1, 8'h22, 32'h12345678, 4'b1000, RD1);
    v[5]  = mk(4'b1000, 4'b0000, 32'h06000000, 128'h0, 4'b1000,
               1'b0, 8'h05, 32'h0, 1'b0, 8'h22, 32'h0, 4'b0010, RD1);
    v[6]  = mk(4'b1111, 4'b0000, 32'h04030201, 128'h0, 4'b0011,
               1'b0, 8'h06, 32'h0, 1'b0, 8'h22, 32'h0, 4'b1001, RD2);
    v[7]  = mk(4'b1111, 4'b0000, 32'h04030201, 128'h0, 4'b1100,
               1'b0, 8'h01, 32'h0, 1'b0, 8'h02, 32'h0, 4'b1000, RD2);
    v[8]  = mk(4'b1111, 4'b0000, 32'h04030201, 128'h0, 4'b0011,
               1'b0, 8'h03, 32'h0, 1'b0, 8'h04, 32'h0, 4'b0011, RD0);
    v[9]  = mk(4'b0011, 4'b0011, 32'h00004040, {64'h0, 32'hBBBB1111, 32'hAAAA0000}, 4'b0001,
               1'b0, 8'h01, 32'h0, 1'b0, 8'h02, 32'h0, 4'b1100, RD0);
    v[10] = mk(4'b0010, 4'b0010, 32'h00004000, {64'h0, 32'hBBBB1111, 32'h0}, 4'b0010,
               1'b1, 8'h40, 32'hAAAA0000, 1'b0, 8'h02, 32'h0, 4'b0011, RD0);
    v[11] = mk(4'b1101, 4'b0100, 32'h50500060, {32'h0, 32'h5555AAAA, 64'h0}, 4'b0101,
               1'b1, 8'h40, 32'hBBBB1111, 1'b0, 8'h02, 32'h0, 4'b0000, RD0);
    v[12] = mk(4'b0110, 4'b0000, 32'h00505000, 128'h0, 4'b0110,
               1'b1, 8'h50, 32'h5555AAAA, 1'b0, 8'h60, 32'h0, 4'b0000, RD0);
    v[13] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000,
               1'b0, 8'h50, 32'h0, 1'b0, 8'h50, 32'h0, 4'b0001, RD0);
    v[14] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000,
               1'b0, 8'h50, 32'h0, 1'b0, 8'h50, 32'h0, 4'b0110, RD3);
    v[15] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000,
               1'b0, 8'h50, 32'h0, 1'b0, 8'h50, 32'h0, 4'b0000, RD3);

    bus.req = 4'b1111; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("reset gnt", bus.gnt, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
    chk("reset busy", busy, 0);
    chk("reset clr_done", clr_done, 0);
    chk("reset ram_en", {bus.ram_en1, bus.ram_en2}, 0);
    chk("reset ram_addr", {bus.ram_addr1, bus.ram_addr2}, 0);
    chk("reset ram_din", {bus.ram_din1, bus.ram_din2}, 0);
    bus.req = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      bus.req = v[r].req; bus.req_we = v[r].we;
      bus.req_addr = v[r].addr; bus.req_wdata = v[r].wd;
      @(negedge clk);
      chk($sformatf("r%0d gnt", r), bus.gnt, v[r].gnt);
      chk($sformatf("r%0d en1", r), bus.ram_en1, v[r].en1);
      chk($sformatf("r%0d addr1", r), bus.ram_addr1, v[r].a1);
      if (v[r].en1) chk($sformatf("r%0d din1", r), bus.ram_din1, v[r].d1);
      chk($sformatf("r%0d en2", r), bus.ram_en2, v[r].en2);
      chk($sformatf("r%0d addr2", r), bus.ram_addr2, v[r].a2);
      if (v[r].en2) chk($sformatf("r%0d din2", r), bus.ram_din2, v[r].d2);
      chk($sformatf("r%0d rsp_valid", r), bus.rsp_valid, v[r].rv);
      chk($sformatf("r%0d rsp_data", r), bus.rsp_data, v[r].rd);
      @(posedge clk); #1;
    end
    chk("mem[40] last writer", mem[8'h40], 32'hBBBB1111);
    chk("mem[10]", mem[8'h10], 32'hDEADBEEF);
    chk("mem[50]", mem[8'h50], 32'h5555AAAA);

    // Clear with req3 held
    do_wr(0, 8'h00, 32'h11111111);
    do_wr(0, 8'h81, 32'h22222222);
    do_wr(0, 8'hFF, 32'h33333333);
    @(posedge clk); #1;
    chk("fill mem[81]", mem[8'h81], 32'h22222222);
    clr_start = 1'b1;
    bus.req[3] = 1'b1; bus.req_we[3] = 1'b0; bus.req_addr[31:24] = 8'h81;
    @(negedge clk);
    chk("clr_start cycle gnt", bus.gnt, 0);
    @(posedge clk); #1 clr_start = 1'b0;
    @(negedge clk);
    chk("busy rise", busy, 1);
    bcnt = 0; bad = 0;
    for (int c = 0; c < 300 && busy; c++) begin
      bcnt++;
      if (bus.gnt != 0) bad++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("busy cycles", bcnt, 128);
    chk("gnt during clear", bad, 0);
    chk("clr_done pulse", clr_done, 1);
    chk("done cycle gnt", bus.gnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_done drop", clr_done, 0);
    chk("post-clear gnt3", bus.gnt, 4'b1000);
    @(posedge clk); #1 bus.req[3] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd3 rsp_valid @81", bus.rsp_valid[3], 1);
    chk("rd3 rsp_data @81", bus.rsp_data[127:96], 0);
    @(posedge clk); #1;
    do_rd(1, 8'h00, 32'h0);
    do_rd(2, 8'hFF, 32'h0);
    nz = 0;
    for (int i = 0; i < 2**AW; i++) if (mem[i] != 0) nz++;
    chk("nonzero words after clear", nz, 0);

    // Reset in the middle of a clear
    clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.ram_en1 && bus.ram_addr1 == 8'h40) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reach clear addr 40", ok, 1);
    bus.req = 4'b0001; bus.req_we = '0; bus.req_addr = 32'h00000007;
    rst_n = 1'b0;
    #1;
    chk("midclr rst busy", busy, 0);
    chk("midclr rst en", {bus.ram_en1, bus.ram_en2}, 0);
    chk("midclr rst addr1", bus.ram_addr1, 0);
    chk("midclr rst gnt", bus.gnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", busy, 0);
    chk("post-reset gnt (ARB)", bus.gnt, 4'b0001);
    @(posedge clk); #1 bus.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
